da_seq_ctrl: RTL and testbench
==============================

// Module: da_seq_ctrl
// PURPOSE
//  Bit-serial distributed-arithmetic sequencer for the adaptive filter's partial-sum tables.
//  - Accepts K signed W-bit samples on a valid/ready handshake.
//  - Walks their bits LSB-first, one bit per cycle, and drives the table address.
//  - Shift-accumulates the returned table word; the MSB (sign) cycle subtracts.
//  - Presents y = sum_k c_k*x_k on a valid/ready output, with c_k held in the table.
// PARAMETERS
//  K     4   samples per table address (tbl_addr width)
//  W     8   sample width, two's complement
//  TW    10  table word width, signed
//  OUT_W 16  y_out width; must be <= ACC_W
//  ACC_W TW+W  accumulator width (localparam)
// PORTS
//  clk        in   1        clock, rising edge
//  r          in   1        synchronous active-high reset
//  in_valid   in   1        x_in valid
//  in_ready   out  1        = (state==IDLE)
//  x_in       in   K*W      sample k at [k*W +: W]
//  tbl_addr   out  K        bit b of each sample; bit k from sample k
//  tbl_en     out  1        table read strobe, high in RUN
//  tbl_msb    out  1        high on sign-bit cycle (b==W-1)
//  tbl_data   in   TW       signed table word for tbl_addr, combinational same cycle
//  y_out      out  OUT_W    result, held while out_valid
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts y_out
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  Reset:
//  - At a clk edge with r=1: state=IDLE, b=0, acc=0, sample regs=0, y_out=0, out_valid=0.
//  - r overrides all other inputs, including mid-RUN and mid-DONE; any partial result is dropped.
//  FSM:
//  - IDLE: in_valid & in_ready captures x_in, acc<=0, b<=0, ->RUN.
//  - RUN: each edge acc <= acc +/- (sext(tbl_data) << b); sign is '-' when b==W-1.
//    Sample regs shift right 1; b++.
//    At b==W-1 load y_out from the final sum and set out_valid, ->DONE.
//  - DONE: out_valid=1, y_out stable. out_valid & out_ready -> IDLE, out_valid<=0.
//  Outputs:
//  - tbl_addr[k] = sample_reg_k[0] in RUN; 0 otherwise.
//  - tbl_en=tbl_msb=0 outside RUN.
//  Timing:
//  - Latency: out_valid rises W edges after the accept edge.
//  - Throughput: with out_ready tied high, one result per W+2 cycles.
//  Handshake:
//  - in_valid is ignored outside IDLE; x_in is sampled only on the accept edge.
//  - out_ready is ignored outside DONE.
//  - out_ready held low stalls in DONE indefinitely; no new input is accepted.
//  Arithmetic:
//  - tbl_data is sign-extended to ACC_W before the shift; no overflow is possible in acc.
//  - Address 0 is driven normally; the table must return 0 for it.
// CONFIGURATION
//  DA_SAT_EN defined: y_out = acc clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  DA_SAT_EN undefined: y_out = acc[OUT_W-1:0] (wraps).
//  Either way the full-width acc is unchanged.
// TESTING
//  Bench table: tbl_data = sum of c_k over set address bits, c=[1,2,3,4].
//  1. All x=1, out_ready=1 -> tbl_addr=4'hF on b=0, then 0.
//     y_out=10; out_valid 8 edges after accept.
//  2. x=[-1,2,-3,4] -> y_out = -1+4-9+16 = 10; tbl_msb high on exactly one cycle,
//     with tbl_addr=4'b0101.
//  3. c=[127,127,127,127], all x=-128 -> acc=-65024;
//     y_out=16'h0200 (no DA_SAT_EN) or 16'h8000 (DA_SAT_EN).
//  4. in_valid held high, out_ready=1, 3 samples -> results 10 cycles apart.
//     in_ready low in between.
//  5. out_ready low for 5 cycles in DONE -> y_out, out_valid stable; in_ready=0.
//     Releases on the next edge with out_ready=1.
//  6. r pulsed at b=3 -> next cycle IDLE, busy=0, out_valid=0.
//     A new sample then gives a correct, uncorrupted y_out.

Source files
------------

// File: rtl/da_seq_ctrl_if.sv
// Handshake and table bus for the distributed-arithmetic sequencer da_seq_ctrl.
// Sample input, table lookup and result output all live on this one bundle.
interface da_seq_ctrl_if #(
    parameter int K     = 4,
    parameter int W     = 8,
    parameter int TW    = 10,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [K*W-1:0]   x_in;
    logic [K-1:0]     tbl_addr;
    logic             tbl_en;
    logic             tbl_msb;
    logic [TW-1:0]    tbl_data;
    logic [OUT_W-1:0] y_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport slave (
        input  in_valid, x_in, tbl_data, out_ready,
        output in_ready, tbl_addr, tbl_en, tbl_msb, y_out, out_valid, busy
    );

    modport master (
        output in_valid, x_in, tbl_data, out_ready,
        input  in_ready, tbl_addr, tbl_en, tbl_msb, y_out, out_valid, busy
    );
endinterface

// File: rtl/da_seq_ctrl.sv
// Bit-serial distributed-arithmetic sequencer: walks K samples LSB-first, shift-accumulates table words.
// Define DA_SAT_EN to clamp y_out to the OUT_W signed range instead of wrapping.
module da_seq_ctrl #(
    parameter int K     = 4,
    parameter int W     = 8,
    parameter int TW    = 10,
    parameter int OUT_W = 16
) (
    input  logic          clk,
    input  logic          r,
    da_seq_ctrl_if.slave  bus
);
    localparam int ACC_W = TW + W;
    localparam int B_W   = (W > 1) ? $clog2(W) : 1;
    localparam logic [B_W-1:0] B_LAST = B_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [B_W-1:0]   r_b;
    logic [ACC_W-1:0] r_acc;
    logic [K*W-1:0]   r_smp;
    logic [OUT_W-1:0] r_y;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_release;
    logic             w_run;
    logic             w_msb;
    logic [K-1:0]     w_addr;
    logic [ACC_W-1:0] w_tbl_ext;
    logic [ACC_W-1:0] w_term;
    logic [ACC_W-1:0] w_sum;
    logic [OUT_W-1:0] w_y_next;

    // State register
    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake qualifiers
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        w_run       = 1'b0;
        w_msb       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.in_valid;
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_run = 1'b1;
                w_msb = (r_b == B_LAST);
                if (r_b == B_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_release = bus.out_ready;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Table address: bit b of every sample sits at the bottom of its shifting lane
    always_comb begin
        w_addr = '0;
        if (w_run) begin
            for (int k = 0; k < K; k++) begin
                w_addr[k] = r_smp[k*W];
            end
        end else begin
            w_addr = '0;
        end
    end

    // Sign bit carries negative weight, so the last cycle subtracts
    always_comb begin
        w_tbl_ext = {{(ACC_W-TW){bus.tbl_data[TW-1]}}, bus.tbl_data};
        w_term    = w_tbl_ext << r_b;
        if (w_msb) begin
            w_sum = r_acc - w_term;
        end else begin
            w_sum = r_acc + w_term;
        end
    end

`ifdef DA_SAT_EN
    logic [ACC_W-OUT_W:0] w_hi;

    // Clamp when the bits above the output sign are not a pure sign extension
    always_comb begin
        w_hi = w_sum[ACC_W-1:OUT_W-1];
        if ((&w_hi) || !(|w_hi)) begin
            w_y_next = w_sum[OUT_W-1:0];
        end else if (w_sum[ACC_W-1]) begin
            w_y_next = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            w_y_next = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    // Wrapping truncation of the final sum
    always_comb begin
        w_y_next = w_sum[OUT_W-1:0];
    end
`endif

    // Datapath: sample capture, shift-accumulate, result hold
    always_ff @(posedge clk) begin
        if (r) begin
            r_b         <= '0;
            r_acc       <= '0;
            r_smp       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_smp <= bus.x_in;
                        r_acc <= '0;
                        r_b   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_sum;
                    for (int k = 0; k < K; k++) begin
                        r_smp[k*W +: W] <= {1'b0, r_smp[k*W+1 +: W-1]};
                    end
                    if (w_msb) begin
                        r_b         <= '0;
                        r_y         <= w_y_next;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_b <= r_b + 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_release) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.tbl_en    = w_run;
    assign bus.tbl_msb   = w_msb;
    assign bus.tbl_addr  = w_addr;
    assign bus.y_out     = r_y;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_da_seq_ctrl.sv
// Scoreboard bench for da_seq_ctrl: y = sum c_k*x_k reference, table synthesised from c[].
// Honours DA_SAT_EN for the expected clamp/wrap behaviour.
module tb_da_seq_ctrl;
    localparam int K     = 4;
    localparam int W     = 8;
    localparam int TW    = 10;
    localparam int OUT_W = 16;

    logic clk = 1'b0;
    logic r   = 1'b1;

    da_seq_ctrl_if #(.K(K), .W(W), .TW(TW), .OUT_W(OUT_W)) bus ();
    da_seq_ctrl #(.K(K), .W(W), .TW(TW), .OUT_W(OUT_W)) dut (.clk(clk), .r(r), .bus(bus));

    always #5 clk = ~clk;

    int c [K];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int rdy_mode = 1;
    int msb_cnt = 0;
    logic [OUT_W-1:0] exp_q [$];
    logic [K*W-1:0]   x_q [$];
    int               acc_q [$];
    int               rise_q [$];
    logic [OUT_W-1:0] last_y = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Partial-sum table: sum of c_k over the set address bits
    int tsum;
    always_comb begin
        tsum = 0;
        for (int k = 0; k < K; k++) begin
            if (bus.tbl_addr[k]) tsum = tsum + c[k];
        end
        bus.tbl_data = tsum[TW-1:0];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [OUT_W-1:0] model(input logic [K*W-1:0] x);
        longint s = 0;
        logic signed [W-1:0] xs;
        logic [63:0] u;
        for (int k = 0; k < K; k++) begin
            xs = x[k*W +: W];
            s  = s + longint'(c[k]) * longint'(xs);
        end
`ifdef DA_SAT_EN
        if (s > (longint'(1) <<< (OUT_W-1)) - 1) s = (longint'(1) <<< (OUT_W-1)) - 1;
        if (s < -(longint'(1) <<< (OUT_W-1)))    s = -(longint'(1) <<< (OUT_W-1));
`endif
        u = s;
        return u[OUT_W-1:0];
    endfunction

    // out_ready driver, owned by one process
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 0)      bus.out_ready = 1'b0;
            else if (rdy_mode == 1) bus.out_ready = 1'b1;
            else                    bus.out_ready = 1'($urandom_range(1, 0));
        end
    end

    // Monitor: table-bus trace, latency, stability and scoreboard pops
    initial begin
        logic prev_ov;
        logic [OUT_W-1:0] prev_y;
        logic [K*W-1:0] xf;
        logic [K-1:0] ea;
        int bidx;
        prev_ov = 1'b0;
        prev_y  = '0;
        forever begin
            @(negedge clk);
            if (!r) begin
                if (bus.tbl_en) begin
                    if (acc_q.size() == 0) begin
                        chk("tbl_en_unexpected", 1, 0);
                    end else begin
                        xf   = x_q[0];
                        bidx = cyc - acc_q[0];
                        for (int k = 0; k < K; k++) ea[k] = xf[k*W + bidx];
                        chk("tbl_addr", bus.tbl_addr, ea);
                        chk("tbl_msb", bus.tbl_msb, (bidx == W-1));
                        if (bus.tbl_msb) msb_cnt++;
                    end
                end else begin
                    chk("idle_addr_zero", {bus.tbl_msb, bus.tbl_addr}, 0);
                end
                if (bus.out_valid && !prev_ov) begin
                    if (acc_q.size() == 0) begin
                        chk("out_valid_unexpected", 1, 0);
                    end else begin
                        chk("latency", cyc - acc_q[0], W);
                        chk("msb_cycles", msb_cnt, 1);
                        void'(acc_q.pop_front());
                        void'(x_q.pop_front());
                    end
                    msb_cnt = 0;
                    rise_q.push_back(cyc);
                end
                if (bus.out_valid) begin
                    chk("in_ready_in_done", {bus.busy, bus.in_ready}, 2'b10);
                    if (prev_ov) chk("y_stable", bus.y_out, prev_y);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("result_unexpected", 1, 0);
                    end else begin
                        chk("y_out", bus.y_out, exp_q.pop_front());
                    end
                    last_y = bus.y_out;
                end
                prev_ov = bus.out_valid;
                prev_y  = bus.y_out;
            end
        end
    end

    task automatic send(input logic [K*W-1:0] x, input bit keep_valid);
        int n = 0;
        bus.x_in     = x;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 1, 0);
        end else begin
            exp_q.push_back(model(x));
            x_q.push_back(x);
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 500) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OUT_W-1:0] t3_exp;
        int n;
        bus.in_valid = 1'b0;
        bus.x_in     = '0;
        c = '{1, 2, 3, 4};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y_out", bus.y_out, 0);
        chk("rst_flags", {bus.out_valid, bus.busy, bus.in_ready, bus.tbl_en, bus.tbl_msb}, 5'b00100);
        chk("rst_addr", bus.tbl_addr, 0);
        r = 1'b0;
        @(posedge clk); #1;

        // 1: all ones -> 10
        send({4{8'd1}}, 1'b0);
        drain();
        chk("t1_y", last_y, 16'd10);

        // 2: mixed signs -> 10, sign cycle addr 0101
        send({8'h04, 8'hFD, 8'h02, 8'hFF}, 1'b0);
        drain();
        chk("t2_y", last_y, 16'd10);

        // 3: large magnitude, wrap or clamp
        c = '{127, 127, 127, 127};
        send({4{8'h80}}, 1'b0);
        drain();
`ifdef DA_SAT_EN
        t3_exp = 16'h8000;
`else
        t3_exp = 16'h0200;
`endif
        chk("t3_y", last_y, t3_exp);

        // 4: back-to-back with in_valid held high
        c = '{1, 2, 3, 4};
        rise_q.delete();
        for (int i = 0; i < 3; i++) send($urandom, (i < 2));
        drain();
        chk("t4_count", rise_q.size(), 3);
        if (rise_q.size() >= 3) begin
            chk("t4_gap0", rise_q[1] - rise_q[0], W + 2);
            chk("t4_gap1", rise_q[2] - rise_q[1], W + 2);
        end

        // 5: stall in DONE
        rdy_mode = 0;
        @(posedge clk); #1;
        send($urandom, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("t5_done", bus.out_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_held", {bus.out_valid, bus.in_ready}, 2'b10);
        rdy_mode = 1;
        #2;
        chk("t5_ready_up", bus.out_ready, 1);
        @(posedge clk); #1;
        chk("t5_release", {bus.out_valid, bus.in_ready}, 2'b01);
        drain();

        // 6: reset mid-RUN at b=3, then a clean result
        send({8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        r = 1'b1;
        exp_q.delete(); x_q.delete(); acc_q.delete(); msb_cnt = 0;
        @(posedge clk); #1;
        r = 1'b0;
        chk("t6_after_rst", {bus.in_ready, bus.busy, bus.out_valid, bus.tbl_en}, 4'b1000);
        send({8'hF0, 8'h07, 8'h80, 8'h7F}, 1'b0);
        drain();
        chk("t6_y", last_y, model({8'hF0, 8'h07, 8'h80, 8'h7F}));

        // Random coefficients, samples and backpressure
        rdy_mode = 2;
        for (int bt = 0; bt < 5; bt++) begin
            drain();
            for (int k = 0; k < K; k++) c[k] = int'($urandom_range(254, 0)) - 127;
            for (int i = 0; i < 20; i++) begin
                send($urandom, 1'($urandom_range(1, 0)));
                if ($urandom_range(3, 0) == 0) begin
                    bus.in_valid = 1'b0;
                    repeat ($urandom_range(12, 1)) @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b0;
        end
        rdy_mode = 1;
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
